// File: rtl/test_seq_pkg.sv
// Shared types and defaults for the test sequencer and its watchdog.
package test_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_FINISH
    } seq_state_e;

    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/seq_watchdog.sv
// Per-unit cycle watchdog: counts enabled cycles and flags when the limit is reached.
module seq_watchdog #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expires on the limit-th enabled cycle since the last clear.
    assign expired = enable && (({1'b0, count_q} + (CNT_W + 1)'(1)) >= {1'b0, limit});

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Walks the enabled method units in index order, handshaking req/busy with each under a watchdog.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_UNITS-1:0] enable_mask,
    output logic               busy,
    output logic               done,
    output logic [N_UNITS-1:0] unit_req,
    input  logic [N_UNITS-1:0] unit_busy,
    output logic [IDX_W-1:0]   cur_unit,
    output logic               timeout_flag,
    output logic [IDX_W-1:0]   timeout_unit,
    output logic [31:0]        pass_cycles
);

    // One extra index bit so the scan can step past the last unit.
    localparam int POS_W = IDX_W + 1;
    localparam int EXT_N = 2 ** POS_W;

    seq_state_e         state_q, state_d;
    logic [POS_W-1:0]   index_q, index_d;
    logic [N_UNITS-1:0] mask_q, mask_d;
    logic               tflag_q, tflag_d;
    logic [IDX_W-1:0]   tunit_q, tunit_d;
    logic [31:0]        pass_q, pass_d;

    logic               wd_clear, wd_enable, wd_expired;
    logic [EXT_N-1:0]   mask_ext, busy_ext;
    logic               sel_enabled, sel_busy, active;

    assign mask_ext    = {{(EXT_N - N_UNITS){1'b0}}, mask_q};
    assign busy_ext    = {{(EXT_N - N_UNITS){1'b0}}, unit_busy};
    assign sel_enabled = mask_ext[index_q];
    assign sel_busy    = busy_ext[index_q];
    assign active      = (state_q == ST_SELECT) || (state_q == ST_ISSUE) ||
                         (state_q == ST_WAIT_DONE);

    seq_watchdog #(.CNT_W(32)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (32'(TIMEOUT)),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        mask_d    = mask_q;
        tflag_d   = tflag_q;
        tunit_d   = tunit_q;
        pass_d    = pass_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;

        if (active && (pass_q != '1)) begin
            pass_d = pass_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = enable_mask;
                    tflag_d = 1'b0;
                    tunit_d = '0;
                    pass_d  = '0;
                    index_d = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (index_q >= POS_W'(N_UNITS)) begin
                    state_d = ST_FINISH;
                end else if (!sel_enabled) begin
                    index_d = index_q + POS_W'(1);
                end else begin
                    wd_clear = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_enable = 1'b1;
                if (wd_expired) begin
                    index_d = index_q + POS_W'(1);
                    state_d = ST_SELECT;
                    tflag_d = 1'b1;
                    if (!tflag_q) tunit_d = index_q[IDX_W-1:0];
                end else if (sel_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                wd_enable = 1'b1;
                // A unit that finishes on the expiry cycle still counts as on time.
                if (!sel_busy) begin
                    index_d = index_q + POS_W'(1);
                    state_d = ST_SELECT;
                end else if (wd_expired) begin
                    index_d = index_q + POS_W'(1);
                    state_d = ST_SELECT;
                    tflag_d = 1'b1;
                    if (!tflag_q) tunit_d = index_q[IDX_W-1:0];
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            mask_q  <= '0;
            tflag_q <= 1'b0;
            tunit_q <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            mask_q  <= mask_d;
            tflag_q <= tflag_d;
            tunit_q <= tunit_d;
            pass_q  <= pass_d;
        end
    end

    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_req
        assign unit_req[gi] = (state_q == ST_ISSUE) && (index_q == POS_W'(gi));
    end

    assign busy         = active;
    assign done         = (state_q == ST_FINISH);
    assign cur_unit     = active ? index_q[IDX_W-1:0] : '0;
    assign timeout_flag = tflag_q;
    assign timeout_unit = tunit_q;
    assign pass_cycles  = pass_q;

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter N_UNITS, default 4: number of controlled method units (1..16).
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles allowed per unit, from first req assertion to busy falling.
REQ-003 Parameter IDX_W, default 4: width of unit index outputs; shall satisfy 2**IDX_W >= N_UNITS.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; sampled only in IDLE; launches one pass over enabled units.
REQ-007 enable_mask  in  N_UNITS  unit i participates when bit i=1; sampled at start acceptance.
REQ-008 busy  out  1  high from cycle after start acceptance until FINISH completes.
REQ-009 done  out  1  one-cycle pulse at end of pass.
REQ-010 unit_req  out  N_UNITS  method request to unit i, at most one bit high.
REQ-011 unit_busy  in  N_UNITS  method busy from unit i.
REQ-012 cur_unit  out  IDX_W  index of unit being serviced; 0 when idle.
REQ-013 timeout_flag  out  1  sticky; set when any unit times out during the current pass.
REQ-014 timeout_unit  out  IDX_W  index of first unit that timed out in the current pass.
REQ-015 pass_cycles  out  32  cycles from start acceptance to done, valid when done pulses, held until the next start is accepted.

Function
REQ-016 FSM states: IDLE, SELECT, ISSUE, WAIT_DONE, FINISH.
REQ-017 IDLE: start=1 -> latch enable_mask, clear timeout_flag, timeout_unit and pass_cycles, set index=0, go to SELECT; busy=1 next cycle.
REQ-018 SELECT: if index >= N_UNITS -> FINISH; else if latched mask bit[index]=0 -> index+1 and stay in SELECT; else clear watchdog, go to ISSUE.
REQ-019 ISSUE: hold unit_req[index]=1; when unit_busy[index]=1, drop req the next cycle and go to WAIT_DONE.
REQ-020 WAIT_DONE: when unit_busy[index]=0 -> index+1, go to SELECT.
REQ-021 Watchdog counts every cycle in ISSUE and WAIT_DONE; reaching TIMEOUT forces unit_req low and index+1, go to SELECT; set timeout_flag; set timeout_unit only if the flag was previously clear.
REQ-022 FINISH: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
REQ-023 pass_cycles increments every cycle while busy=1 and saturates at 2**32-1.
REQ-024 start held high continuously launches a new pass on the cycle after FINISH; start while busy is ignored.
REQ-025 enable_mask all zero: pass completes with done exactly N_UNITS+2 cycles after start acceptance, no unit_req activity.
REQ-026 unit_busy already high on ISSUE entry counts as acknowledge in that cycle.
REQ-027 Changes on enable_mask during a pass have no effect.

Reset
REQ-028 reset=1 at any edge, including mid-pass, returns the FSM to IDLE with unit_req=0, busy=0, done=0, cur_unit=0, timeout_flag=0, timeout_unit=0, pass_cycles=0, watchdog=0; reset overrides start.

Structure
REQ-029 Package test_seq_pkg holds the FSM state enum and the default TIMEOUT constant.
REQ-030 Watchdog shall be a sub-module seq_watchdog (clear, enable, limit inputs; expired output).

Verification
REQ-031 Mask=4'b1111, each unit acknowledges 1 cycle after req and stays busy 5 cycles -> req pulses go to units 0,1,2,3 in order; one done; timeout_flag=0.
REQ-032 Mask=4'b0000, start pulse -> done exactly 6 cycles after acceptance; unit_req stays 0.
REQ-033 TIMEOUT=16, unit 2 never raises busy, mask=4'b1111 -> unit_req[2] drops after 16 cycles; timeout_flag=1; timeout_unit=2; unit 3 still serviced.
REQ-034 Reset asserted while waiting on unit 1 -> next cycle: state IDLE, unit_req=0, busy=0; a fresh start begins again at unit 0.
REQ-035 start held high, mask=4'b0101 -> back-to-back passes; only units 0 and 2 receive req; pass_cycles is identical on each done.
REQ-036 Unit 1 busy already high at ISSUE entry, drops 3 cycles later -> unit_req[1] is high for exactly 1 cycle; no timeout.
